// File: rtl/a0_uart_tx_if.sv
// Signal bundle between the a0 source (CPU/bench) and the UART hex dumper.
// The master drives a0/en; the slave returns the serial line and status.
interface a0_uart_tx_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] a0;
    logic                  en;
    logic                  tx;
    logic                  busy;
    logic                  pending;
    logic [7:0]            drop_count;

    modport master (output a0, en, input tx, busy, pending, drop_count);
    modport slave  (input a0, en, output tx, busy, pending, drop_count);
endinterface

// File: rtl/a0_uart_tx.sv
// Watches the CPU a0 register and streams each new value over UART as
// 8 uppercase hex characters plus '\n', with a one-entry pending buffer.
module a0_uart_tx #(
    parameter int DATA_WIDTH   = 32,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic          clk,
    input  logic          rst,
    a0_uart_tx_if.slave   bus
);
    localparam int BW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    logic [1:0]            state_q, state_d;
    logic [BW-1:0]         baud_q, baud_d;
    logic [2:0]            bit_q, bit_d;
    logic [3:0]            byte_q, byte_d;
    logic [DATA_WIDTH-1:0] frame_q, frame_d;
    logic [DATA_WIDTH-1:0] pval_q, pval_d;
    logic                  pend_q, pend_d;
    logic [7:0]            drop_q, drop_d;
    logic [DATA_WIDTH-1:0] prev_a0_q;
    logic                  tx_q, tx_d;
    logic                  busy_q;

    logic                  change;
    logic                  baud_last;
    logic                  frame_end;
    logic [7:0]            cur_byte;

    // Byte idx of the frame: nibbles MSB first, then the newline terminator.
    function automatic logic [7:0] frame_byte(input logic [31:0] f, input logic [3:0] idx);
        logic [3:0] n;
        if (idx >= 4'd8) return 8'h0A;
        n = f[31 - 4*int'(idx) -: 4];
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    assign change    = bus.en && (bus.a0 != prev_a0_q);
    assign baud_last = (baud_q == BW'(CLKS_PER_BIT - 1));
    assign frame_end = (state_q == STOP) && baud_last && (byte_q == 4'd8);

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        frame_d = frame_q;
        pval_d  = pval_q;
        pend_d  = pend_q;
        drop_d  = drop_q;

        case (state_q)
            IDLE: begin
                if (change) begin
                    frame_d = bus.a0;
                    state_d = START;
                    baud_d  = '0;
                    byte_d  = 4'd0;
                end
            end
            START: begin
                if (baud_last) begin
                    state_d = DATA;
                    bit_d   = 3'd0;
                    baud_d  = '0;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            DATA: begin
                if (baud_last) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) state_d = STOP;
                    else               bit_d   = bit_q + 3'd1;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: begin
                if (baud_last) begin
                    baud_d = '0;
                    if (byte_q != 4'd8) begin
                        byte_d  = byte_q + 4'd1;
                        state_d = START;
                    end else if (change) begin
                        // Newest value bypasses the buffer so the line never idles.
                        frame_d = bus.a0;
                        byte_d  = 4'd0;
                        state_d = START;
                    end else if (pend_q) begin
                        frame_d = pval_q;
                        pend_d  = 1'b0;
                        byte_d  = 4'd0;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
        endcase

        if (change && (state_q != IDLE)) begin
            if (frame_end) begin
                pend_d = 1'b0;
            end else begin
                pval_d = bus.a0;
                pend_d = 1'b1;
            end
            if (pend_q && (drop_q != 8'hFF)) drop_d = drop_q + 8'd1;
        end
    end

    // tx is registered from the next-state view so it lines up with busy.
    always_comb begin
        cur_byte = frame_byte(frame_d, byte_d);
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = cur_byte[bit_d];
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            baud_q    <= '0;
            bit_q     <= '0;
            byte_q    <= '0;
            frame_q   <= '0;
            pval_q    <= '0;
            pend_q    <= 1'b0;
            drop_q    <= '0;
            prev_a0_q <= '0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_q     <= bit_d;
            byte_q    <= byte_d;
            frame_q   <= frame_d;
            pval_q    <= pval_d;
            pend_q    <= pend_d;
            drop_q    <= drop_d;
            prev_a0_q <= bus.a0;
            tx_q      <= tx_d;
            busy_q    <= (state_d != IDLE);
        end
    end

    assign bus.tx         = tx_q;
    assign bus.busy       = busy_q;
    assign bus.pending    = pend_q;
    assign bus.drop_count = drop_q;
endmodule

// File: tb/tb_a0_uart_tx.sv
// Directed bench for a0_uart_tx: decodes tx into bytes and compares frames,
// busy length, buffering and reset behaviour against hand-computed values.
module tb_a0_uart_tx;
    localparam int C = 4;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;
    logic [7:0] rxq[$];

    a0_uart_tx_if #(.DATA_WIDTH(32)) u_if ();

    a0_uart_tx #(.DATA_WIDTH(32), .CLKS_PER_BIT(C)) dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if.slave)
    );

    always #5 clk = ~clk;

    // Serial receiver: samples mid-bit on falling edges, drops bytes cut by reset.
    initial begin
        logic [7:0] b;
        logic       ok;
        forever begin
            @(negedge clk);
            if (!rst && u_if.tx === 1'b0) begin
                ok = 1'b1;
                b  = 8'h00;
                for (int i = 0; i < 8; i++) begin
                    repeat (C) @(negedge clk);
                    if (rst) ok = 1'b0;
                    b[i] = u_if.tx;
                end
                repeat (C) @(negedge clk);
                if (rst || u_if.tx !== 1'b1) ok = 1'b0;
                if (ok) rxq.push_back(b);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wait_bytes(input int n);
        int t = 0;
        while (rxq.size() < n && t < 3000) begin
            @(negedge clk);
            t++;
        end
        chk("rx_timeout", rxq.size() >= n, 1);
    endtask

    task automatic check_frame(input string tag, input string exp);
        logic [7:0] b;
        wait_bytes(9);
        for (int i = 0; i < 9; i++) begin
            b = (rxq.size() > 0) ? rxq.pop_front() : 8'hxx;
            chk($sformatf("%s[%0d]", tag, i), {24'h0, b}, {24'h0, exp[i]});
        end
    endtask

    // Applies v0, optionally v1/v2 mid-frame, and counts cycles busy stays high.
    task automatic send(input logic [31:0] v0, input logic [31:0] v1, input logic [31:0] v2,
                        input int nchg, output int len, output logic pend_mid);
        int t = 0;
        u_if.a0 = v0;
        len = 0;
        pend_mid = 1'b0;
        while (!u_if.busy && t < 20) begin
            @(negedge clk);
            t++;
        end
        while (u_if.busy && len < 2000) begin
            if (nchg >= 1 && len == 50)  u_if.a0 = v1;
            if (nchg >= 2 && len == 100) u_if.a0 = v2;
            if (nchg >= 1 && len == 52)  pend_mid = u_if.pending;
            len++;
            @(negedge clk);
        end
    endtask

    initial begin
        int   len;
        logic pm;
        logic saw_busy, saw_low;

        rst = 1'b1;
        u_if.a0 = 32'h0;
        u_if.en = 1'b0;
        #1;
        chk("rst_tx", u_if.tx, 1);
        chk("rst_busy", u_if.busy, 0);
        chk("rst_pend", u_if.pending, 0);
        chk("rst_drop", u_if.drop_count, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        u_if.en = 1'b1;
        repeat (3) @(negedge clk);

        send(32'h0000_00FF, 32'h0, 32'h0, 0, len, pm);
        chk("ff_busy_len", len, 360);
        check_frame("ff", "000000FF\n");
        chk("ff_tx_idle", u_if.tx, 1);
        chk("ff_drop", u_if.drop_count, 0);

        repeat (5) @(negedge clk);
        send(32'hDEAD_BEEF, 32'h0, 32'h0, 0, len, pm);
        chk("dead_busy_len", len, 360);
        check_frame("dead", "DEADBEEF\n");

        repeat (5) @(negedge clk);
        send(32'h1, 32'h2, 32'h0, 1, len, pm);
        chk("pend_mid", pm, 1);
        chk("b2b_busy_len", len, 720);
        check_frame("b2b_a", "00000001\n");
        check_frame("b2b_b", "00000002\n");
        chk("b2b_pend", u_if.pending, 0);
        chk("b2b_drop", u_if.drop_count, 0);

        repeat (5) @(negedge clk);
        send(32'h1, 32'h2, 32'h3, 2, len, pm);
        chk("ovr_busy_len", len, 720);
        check_frame("ovr_a", "00000001\n");
        check_frame("ovr_b", "00000003\n");
        chk("ovr_drop", u_if.drop_count, 1);
        chk("ovr_pend", u_if.pending, 0);

        repeat (5) @(negedge clk);
        u_if.en = 1'b0;
        u_if.a0 = 32'h5;
        repeat (5) @(negedge clk);
        u_if.a0 = 32'h9;
        repeat (5) @(negedge clk);
        u_if.en = 1'b1;
        saw_busy = 1'b0;
        saw_low  = 1'b0;
        repeat (50) begin
            @(negedge clk);
            if (u_if.busy) saw_busy = 1'b1;
            if (u_if.tx !== 1'b1) saw_low = 1'b1;
        end
        chk("en0_busy", saw_busy, 0);
        chk("en0_tx", saw_low, 0);
        chk("en0_rx", rxq.size(), 0);

        u_if.a0 = 32'h1234_5678;
        wait_bytes(4);
        repeat (2 * C) @(negedge clk);
        chk("mid_busy_pre", u_if.busy, 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_tx", u_if.tx, 1);
        chk("mid_rst_busy", u_if.busy, 0);
        chk("mid_rst_pend", u_if.pending, 0);
        u_if.a0 = 32'h0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (100) @(negedge clk);
        chk("post_rst_busy", u_if.busy, 0);
        rxq.delete();
        send(32'hCAFE_0123, 32'h0, 32'h0, 0, len, pm);
        chk("post_rst_len", len, 360);
        check_frame("post_rst", "CAFE0123\n");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/a0_uart_tx.md
Name: a0_uart_tx

Overview:
- Downstream consumer of the CPU's a0 result register.
- Watches a0 every cycle. On each change, sends the new value out a serial UART line as 8 uppercase ASCII hex characters followed by '\n'.
- Holds one pending value so a second change during a frame is not lost. Counts values it has to discard.
- Gives the bench and the board a result readout that needs no display hardware.

Parameters:
- DATA_WIDTH, 32, width of the a0 input. Fixed at 32; the frame format depends on it.
- CLKS_PER_BIT, 16, clock cycles per UART bit. Must be >= 2.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- a0  input  DATA_WIDTH  CPU a0 register value.
- en  input  1  change-detect enable.
- tx  output  1  UART serial line, idle high; registered.
- busy  output  1  high while a frame is in progress.
- pending  output  1  high while a captured value waits for the line.
- drop_count  output  8  number of discarded values; saturating.

Behaviour:
Reset
- Asynchronous, active-high.
- On assert: tx=1, busy=0, pending=0, drop_count=0, internal prev_a0=0, state=IDLE, all counters 0.
- Reset mid-frame abandons the frame immediately; tx returns high asynchronously.

Change detect
- prev_a0 <= a0 on every clock edge, regardless of en.
- change = en && (a0 != prev_a0), evaluated combinationally from the current a0.
- Changes that occur while en=0 are absorbed and never sent.

Frame format
- 9 bytes per frame: hex nibbles a0[31:28] down to a0[3:0], then 0x0A.
- Nibble n maps to 0x30+n for 0..9 and to 0x41+(n-10) for 10..15.
- Each byte: start bit 0, 8 data bits LSB first, stop bit 1.
- Each bit holds for exactly CLKS_PER_BIT cycles.
- Frame length: 90*CLKS_PER_BIT cycles.

State machine: IDLE, START, DATA, STOP
- Counters: baud_cnt (0..CLKS_PER_BIT-1), bit_idx (0..7), byte_idx (0..8).
- IDLE:
  - On an edge with change=1, latch a0 into the frame register.
  - Go to START with byte_idx=0; tx=0 from that edge.
- START: after CLKS_PER_BIT cycles, go to DATA with bit_idx=0.
- DATA: shift bits out LSB first. After bit 7's period, go to STOP.
- STOP, when the period ends with byte_idx<8: byte_idx++, go to START.
- STOP, when the period ends with byte_idx==8 (frame end):
  - If pending=1, load the pending value, clear pending, go straight to START. No idle gap.
  - Otherwise go to IDLE.
- busy = (state != IDLE). It is registered, so it rises on the same edge tx first drops.

Buffering (one entry)
- change=1 while busy, and not at a frame-end edge: write a0 into the pending register and set pending=1.
- If pending was already 1, overwrite it and increment drop_count (saturates at 255). Newest value wins.
- change=1 exactly on a frame-end edge: a0 (newest) is loaded straight into the frame register, so transmission never stalls on the buffer.
  - If pending was 1, the old pending value is discarded, drop_count++, pending=0.
- The frame register is stable for the whole frame; later changes to a0 never alter a frame in progress.

Test Plan:
- CLKS_PER_BIT=4; after reset, a0 0 -> 0x000000FF -> bytes 30 30 30 30 30 30 46 46 0A decoded from tx. busy high exactly 360 cycles, tx=1 afterward, drop_count=0.
- a0=0xDEADBEEF -> bytes 44 45 41 44 42 45 45 46 0A (uppercase hex check).
- a0 -> 0x1, then 0x2 mid-frame -> pending=1. Second frame "00000002\n" starts on the edge the first frame ends (no idle cycle). pending=0 afterward, drop_count=0.
- a0 -> 0x1, then 0x2, then 0x3 during the first frame -> frames "00000001\n", "00000003\n", drop_count=1.
- en=0 while a0 changes 5 -> 9, then en=1 with a0 held -> no frame; tx stays 1, busy=0.
- Assert rst at byte 4 of a frame -> tx=1, busy=0, pending=0 immediately. After release, a new change produces a complete, correct frame.
